// File: rtl/dual_alu_pkg.sv
// Shared opcode encodings and bit positions for the dual 4-bit ALU pad block.
package dual_alu_pkg;

   localparam int unsigned PAD_W  = 38;
   localparam int unsigned OPND_W = 4;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned RES_W  = 15;

   localparam logic [SEL_W-1:0] OP_ADD = 2'b00;
   localparam logic [SEL_W-1:0] OP_SUB = 2'b01;
   localparam logic [SEL_W-1:0] OP_AND = 2'b10;
   localparam logic [SEL_W-1:0] OP_XOR = 2'b11;

   // Operand/opcode field LSBs on io_in
   localparam int unsigned A0_LSB   = 18;
   localparam int unsigned B0_LSB   = 22;
   localparam int unsigned A1_LSB   = 26;
   localparam int unsigned B1_LSB   = 30;
   localparam int unsigned SEL0_LSB = 34;
   localparam int unsigned SEL1_LSB = 36;

   // Result vector layout
   localparam int unsigned RES_C0 = 0;
   localparam int unsigned RES_Z0 = 1;
   localparam int unsigned RES_V0 = 2;
   localparam int unsigned RES_R0 = 3;
   localparam int unsigned RES_N0 = 7;
   localparam int unsigned RES_R1 = 8;
   localparam int unsigned RES_Z1 = 12;
   localparam int unsigned RES_C1 = 13;
   localparam int unsigned RES_V1 = 14;

endpackage

// File: rtl/dual_alu4_io_alu4.sv
// Combinational 4-bit ALU: ADD/SUB/AND/XOR with C, V, Z, N flags.
module alu4
   import dual_alu_pkg::*;
(
   input  logic [OPND_W-1:0] i_a,
   input  logic [OPND_W-1:0] i_b,
   input  logic [SEL_W-1:0]  i_sel,
   output logic [OPND_W-1:0] o_r,
   output logic              o_c,
   output logic              o_v,
   output logic              o_z,
   output logic              o_n
);

   logic [OPND_W:0] w_sum;

   always_comb begin
      w_sum = '0;
      o_r   = '0;
      o_c   = 1'b0;
      o_v   = 1'b0;
      case (i_sel)
         OP_ADD: begin
            w_sum = {1'b0, i_a} + {1'b0, i_b};
            o_r   = w_sum[OPND_W-1:0];
            o_c   = w_sum[OPND_W];
            o_v   = (i_a[3] == i_b[3]) && (o_r[3] != i_a[3]);
         end
         OP_SUB: begin
            // C=1 means no borrow, so carry comes straight from A+~B+1
            w_sum = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;
            o_r   = w_sum[OPND_W-1:0];
            o_c   = w_sum[OPND_W];
            o_v   = (i_a[3] != i_b[3]) && (o_r[3] != i_a[3]);
         end
         OP_AND:  o_r = i_a & i_b;
         default: o_r = i_a ^ i_b;
      endcase
      o_z = (o_r == '0);
      o_n = o_r[3];
   end

endmodule

// File: rtl/dual_alu4_io.sv
// Two independent 4-bit ALUs fed from mprj_io pads; flags and results
// are registered once and returned on io_out[17:4] and io_out[0].
module dual_alu4_io
   import dual_alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PAD_W-1:0] io_in,
   output logic [PAD_W-1:0] io_out,
   output logic [PAD_W-1:0] io_oeb
);

   logic [OPND_W-1:0] w_r0, w_r1;
   logic              w_c0, w_v0, w_z0, w_n0;
   logic              w_c1, w_v1, w_z1, w_n1;
   logic [RES_W-1:0]  w_res;
   logic [RES_W-1:0]  r_res;
   logic              w_unused;

   alu4 u_alu0 (
      .i_a   (io_in[A0_LSB +: OPND_W]),
      .i_b   (io_in[B0_LSB +: OPND_W]),
      .i_sel (io_in[SEL0_LSB +: SEL_W]),
      .o_r   (w_r0),
      .o_c   (w_c0),
      .o_v   (w_v0),
      .o_z   (w_z0),
      .o_n   (w_n0)
   );

   alu4 u_alu1 (
      .i_a   (io_in[A1_LSB +: OPND_W]),
      .i_b   (io_in[B1_LSB +: OPND_W]),
      .i_sel (io_in[SEL1_LSB +: SEL_W]),
      .o_r   (w_r1),
      .o_c   (w_c1),
      .o_v   (w_v1),
      .o_z   (w_z1),
      .o_n   (w_n1)
   );

   // Low pads and ALU1's N have no destination
   assign w_unused = ^{io_in[A0_LSB-1:0], w_n1};

   always_comb begin
      w_res                       = '0;
      w_res[RES_C0]               = w_c0;
      w_res[RES_Z0]               = w_z0;
      w_res[RES_V0]               = w_v0;
      w_res[RES_R0 +: OPND_W]     = w_r0;
      w_res[RES_N0]               = w_n0;
      w_res[RES_R1 +: OPND_W]     = w_r1;
      w_res[RES_Z1]               = w_z1;
      w_res[RES_C1]               = w_c1;
      w_res[RES_V1]               = w_v1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_res <= '0;
      else        r_res <= w_res;
   end

   assign io_out = {20'b0, r_res[RES_W-1:1], 3'b0, r_res[0]};
   assign io_oeb = {20'hFFFFF, 14'b0, 3'b111, 1'b0};

endmodule

// File: tb/tb_dual_alu4_io.sv
// Directed bench for dual_alu4_io: reset, each opcode, flags, latency, async reset.
module tb_dual_alu4_io;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [37:0] io_in;
   logic [37:0] io_out;
   logic [37:0] io_oeb;

   int n_cmp = 0;
   int n_mis = 0;

   localparam logic [37:0] OEB_EXP = {20'hFFFFF, 14'b0, 3'b111, 1'b0};

   dual_alu4_io dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_in  (io_in),
      .io_out (io_out),
      .io_oeb (io_oeb)
   );

   always #5 clk = ~clk;

   function automatic logic [37:0] pads(input logic [3:0] a0, b0, a1, b1,
                                        input logic [1:0] s0, s1);
      logic [37:0] p;
      p = {s1, s0, b1, a1, b0, a0, 18'bx};
      return p;
   endfunction

   function automatic logic [37:0] out_of(input logic [14:0] res);
      return {20'b0, res[14:1], 3'b0, res[0]};
   endfunction

   task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      io_in = pads(4'h9, 4'h9, 4'h0, 4'h0, 2'b00, 2'b00);
      #2;
      chk("oeb_in_reset", io_oeb, OEB_EXP);
      step();
      step();
      chk("reset_out", io_out, 38'h0);
      chk("oeb_reset_clocked", io_oeb, OEB_EXP);

      rst_n = 1'b1;
      step();
      chk("add_9p9_0p0", io_out, out_of(15'b001000000010101));
      chk("add_pads_raw", io_out, {20'b0, 14'b00100000001010, 3'b0, 1'b1});

      io_in = pads(4'h5, 4'h3, 4'h7, 4'h7, 2'b01, 2'b01);
      #1;
      chk("latency_hold", io_out, out_of(15'b001000000010101));
      step();
      chk("sub_5m3_7m7", io_out, out_of({7'h30, 8'h11}));

      // logic ops on ALU0; ALU1 ADD wraps F+1 to zero with carry
      io_in = pads(4'hC, 4'hA, 4'hF, 4'h1, 2'b10, 2'b00);
      step();
      chk("and_C_A_add_F1", io_out, out_of({7'h30, 8'hC0}));

      io_in = pads(4'hF, 4'hF, 4'hF, 4'h5, 2'b11, 2'b10);
      step();
      chk("xor_FF_and_F5", io_out, out_of({7'h05, 8'h02}));

      io_in = pads(4'h7, 4'h1, 4'hA, 4'h5, 2'b00, 2'b11);
      step();
      chk("ovf_7p1_xor_A5", io_out, out_of({7'h0F, 8'hC4}));

      // SUB borrow on ALU0; SUB signed overflow on ALU1 (-8 - 1)
      io_in = pads(4'h3, 4'h5, 4'h8, 4'h1, 2'b01, 2'b01);
      step();
      chk("sub_borrow_sub_ovf", io_out, out_of({7'h67, 8'hF0}));

      // Async reset must clear without a clock edge
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_reset_clear", io_out, 38'h0);
      chk("oeb_async_reset", io_oeb, OEB_EXP);
      @(posedge clk);
      #1;
      chk("reset_hold_edge", io_out, 38'h0);

      rst_n = 1'b1;
      io_in = pads(4'h9, 4'h9, 4'h0, 4'h0, 2'b00, 2'b00);
      step();
      chk("resume_after_reset", io_out, out_of(15'b001000000010101));
      chk("oeb_final", io_oeb, OEB_EXP);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
